neuron_layer_seq: RTL and testbench
===================================

# neuron_layer_seq

Sequencer for one fully-connected layer built on a single shared `Neuron` multiply-accumulate unit. It evaluates output neurons one at a time:
- fetches the bias, pixel and weight operands from synchronous-read memories;
- drives the Neuron's `clear`, `set_bias` and `active` strobes;
- writes each finished sum, optionally ReLU-clamped, into a result memory.

It sits between the layer's operand/result RAMs and the Neuron instance and is started by the core's accelerator CSR.

## Interface
- `N_INPUTS`, 784, pixels and weights per output neuron (≥1)
- `N_NEURONS`, 10, output neurons in the layer (≥1)
- `W_RESULT`, 32, width of Neuron sum, bias and result data
- `RELU`, 1, 1 = clamp negative results (two's complement) to 0 on write; 0 = pass through
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin layer when idle; ignored while busy
- `abort`  in  1  cancel current layer; wins over every other event
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last result write
- `bias_addr`  out  clog2(N_NEURONS)  bias RAM read address
- `pix_addr`  out  clog2(N_INPUTS)  pixel RAM read address
- `w_addr`  out  clog2(N_NEURONS*N_INPUTS)  weight RAM read address, row-major [neuron][input]
- `n_clear`, `n_set_bias`, `n_active`  out  1 each  Neuron control strobes
- `n_sigma`  in  W_RESULT  Neuron registered sum
- `res_we`  out  1  result RAM write enable
- `res_addr`  out  clog2(N_NEURONS)  result write address
- `res_data`  out  W_RESULT  result write data

## Operation
- All operand RAMs have exactly 1-cycle read latency: an address driven in cycle t gives data valid in cycle t+1. The Neuron consumes that data in the same cycle t+1.
- Counters:
  - j = neuron index;
  - i = input index;
  - w = weight address, an incrementing counter with no multiplier, so w = j*N_INPUTS+i.
- States and transitions:
  - IDLE: outputs quiet. `start`=1 → `n_clear`=1 for that cycle, j=0, w=0, go BIAS.
  - BIAS: drive `bias_addr`=j. Go LOAD.
  - LOAD: `n_set_bias`=1 (bias data valid). Drive `pix_addr`=0, `w_addr`=w. Set i=0, go ACC.
  - ACC: `n_active`=1 (operands of index i valid).
    - If i<N_INPUTS-1: drive `pix_addr`=i+1 and `w_addr`=w+1, then i++ and w++.
    - If i=N_INPUTS-1: w++, go STORE.
  - STORE: `res_we`=1, `res_addr`=j, `res_data`=f(`n_sigma`).
    - j=N_NEURONS-1 → DONE.
    - Otherwise j++, go BIAS.
  - DONE: `done`=1. Go IDLE.
- f(x): if RELU=1 and x[W_RESULT-1]=1, f = 0; otherwise f = x. No saturation or truncation.
- Addresses are don't-care when their state does not drive them, but the RTL holds their last value.
- `abort` in any non-IDLE state:
  - `n_clear`=1 that cycle, go IDLE.
  - No `res_we` in that cycle and no `done`.
  - Results already written remain.
- `start` asserted together with `abort` while IDLE: `abort` wins and `start` is dropped.
- `start` while busy is ignored, with no queueing.
- Strobes are mutually exclusive: at most one of `n_clear`, `n_set_bias`, `n_active` is high per cycle.

## Timing
- Reset values: all outputs 0, state IDLE, j=i=w=0.
- Per neuron: N_INPUTS+3 cycles (BIAS, LOAD, N_INPUTS×ACC, STORE).
- Layer latency: `start` cycle, then N_NEURONS*(N_INPUTS+3) cycles, then the DONE cycle.
- `busy` = state≠IDLE, registered. It rises the cycle after `start` and falls the cycle after the `done` pulse.
- `n_sigma` is sampled in STORE, one cycle after the last `n_active`. The Neuron's registered sum is final there.
- A new `start` is accepted the cycle after DONE, i.e. the first IDLE cycle.
- `rstn` low mid-layer: immediate return to IDLE with all outputs 0. No partial write is completed.

## Test plan
- Basic, with N_INPUTS=4, N_NEURONS=2, RELU=0. Setup:
  - pixels = 1,2,3,4;
  - weights row0 = 1,1,1,1; row1 = 2,0,0,1;
  - biases = 10, −5.
  - Required: `res_we` pulses with (addr 0, data 20) and (addr 1, data 1), `done` exactly 15 cycles after `start`, `busy` high for 15 cycles.
- ReLU: same setup with RELU=1 and bias1 = −20 → result1 = 0 (sum −14 clamped); result0 = 20 unchanged.
- Address trace: check per cycle that `w_addr` runs 0..3 then 4..7 with no gaps or repeats, that `pix_addr` resets to 0 per neuron, and that `n_active` is high exactly 4 cycles per neuron.
- Abort: assert `abort` in the 3rd ACC cycle of neuron 1. Required: `n_clear`=1 that cycle, no write to addr 1, no `done`, `busy` low next cycle. A restart then produces correct results 20 and 1.
- Start-while-busy and start+abort in IDLE: neither changes the sequence; the second case does not start.
- Async reset: drop `rstn` mid-ACC. All outputs read 0 immediately and the state is IDLE. After release, a `start` runs the layer to completion normally.

Source files
------------

// File: rtl/neuron_layer_seq.sv
// Sequences one fully-connected layer over a shared Neuron MAC: per neuron BIAS, LOAD,
// N_INPUTS x ACC, STORE (N_INPUTS+3 cycles), then one DONE cycle; no backpressure, abort wins.
module neuron_layer_seq #(
    parameter int N_INPUTS  = 784,
    parameter int N_NEURONS = 10,
    parameter int W_RESULT  = 32,
    parameter int RELU      = 1,
    localparam int JW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int WW = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [JW-1:0]       bias_addr,
    output logic [IW-1:0]       pix_addr,
    output logic [WW-1:0]       w_addr,
    output logic                n_clear,
    output logic                n_set_bias,
    output logic                n_active,
    input  logic [W_RESULT-1:0] n_sigma,
    output logic                res_we,
    output logic [JW-1:0]       res_addr,
    output logic [W_RESULT-1:0] res_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_LOAD, S_ACC, S_STORE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [JW-1:0]       j_q, j_d;
    logic [IW-1:0]       i_q, i_d;
    logic [WW-1:0]       w_q, w_d;
    logic [JW-1:0]       bias_addr_q, res_addr_q;
    logic [IW-1:0]       pix_addr_q;
    logic [WW-1:0]       w_addr_q;
    logic [W_RESULT-1:0] res_data_q;
    logic [W_RESULT-1:0] sigma_f;

    assign sigma_f = ((RELU != 0) && n_sigma[W_RESULT-1]) ? '0 : n_sigma;
    assign busy    = (state_q != S_IDLE);

    // Addresses and result bus fall back to their last driven value outside their own state.
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        i_d        = i_q;
        w_d        = w_q;
        bias_addr  = bias_addr_q;
        pix_addr   = pix_addr_q;
        w_addr     = w_addr_q;
        res_addr   = res_addr_q;
        res_data   = res_data_q;
        n_clear    = 1'b0;
        n_set_bias = 1'b0;
        n_active   = 1'b0;
        res_we     = 1'b0;
        done       = 1'b0;
        if (state_q != S_IDLE && abort) begin
            n_clear = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        n_clear = 1'b1;
                        j_d     = '0;
                        w_d     = '0;
                        state_d = S_BIAS;
                    end
                end
                S_BIAS: begin
                    bias_addr = j_q;
                    state_d   = S_LOAD;
                end
                S_LOAD: begin
                    n_set_bias = 1'b1;
                    pix_addr   = '0;
                    w_addr     = w_q;
                    i_d        = '0;
                    state_d    = S_ACC;
                end
                S_ACC: begin
                    n_active = 1'b1;
                    w_d      = w_q + WW'(1);
                    if (i_q != IW'(N_INPUTS - 1)) begin
                        pix_addr = i_q + IW'(1);
                        w_addr   = w_q + WW'(1);
                        i_d      = i_q + IW'(1);
                    end else begin
                        state_d = S_STORE;
                    end
                end
                S_STORE: begin
                    res_we   = 1'b1;
                    res_addr = j_q;
                    res_data = sigma_f;
                    if (j_q == JW'(N_NEURONS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        j_d     = j_q + JW'(1);
                        state_d = S_BIAS;
                    end
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            j_q         <= '0;
            i_q         <= '0;
            w_q         <= '0;
            bias_addr_q <= '0;
            pix_addr_q  <= '0;
            w_addr_q    <= '0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            i_q         <= i_d;
            w_q         <= w_d;
            bias_addr_q <= bias_addr;
            pix_addr_q  <= pix_addr;
            w_addr_q    <= w_addr;
            res_addr_q  <= res_addr;
            res_data_q  <= res_data;
        end
    end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Bench for neuron_layer_seq: two instances (RELU=0 and RELU=1) with RAM and Neuron models,
// a cycle-timeline model of the layer, and directed scenarios with literal result checks.
module tb_neuron_layer_seq;
    localparam int NI = 4, NN = 2, PER = NI + 3, TOT = NN * PER;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
    logic busy[2], done[2], n_clear[2], n_set_bias[2], n_active[2], res_we[2];
    logic [0:0]  bias_addr[2], res_addr[2];
    logic [1:0]  pix_addr[2];
    logic [2:0]  w_addr[2];
    logic [31:0] res_data[2], sig[2], b_rd[2], p_rd[2], w_rd[2];

    int pix[NI], wt[NN*NI], bias[NN];
    int checks = 0, errors = 0;
    int k = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
    int done_cnt[2], busy_cnt[2], act_cnt[2];
    int base, d0, bc0, bc1, ac0;

    typedef struct {int g; int a; int d;} wr_t;
    wr_t wlog[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gd
        neuron_layer_seq #(.N_INPUTS(NI), .N_NEURONS(NN), .W_RESULT(32), .RELU(g)) dut (
            .clk(clk), .rstn(rstn), .start(start), .abort(abort),
            .busy(busy[g]), .done(done[g]),
            .bias_addr(bias_addr[g]), .pix_addr(pix_addr[g]), .w_addr(w_addr[g]),
            .n_clear(n_clear[g]), .n_set_bias(n_set_bias[g]), .n_active(n_active[g]),
            .n_sigma(sig[g]),
            .res_we(res_we[g]), .res_addr(res_addr[g]), .res_data(res_data[g])
        );
    end

    // Synchronous-read operand RAMs and the Neuron's registered accumulator.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            b_rd[g] <= bias[bias_addr[g]];
            p_rd[g] <= pix[pix_addr[g]];
            w_rd[g] <= wt[w_addr[g]];
            if (n_clear[g])         sig[g] <= '0;
            else if (n_set_bias[g]) sig[g] <= b_rd[g];
            else if (n_active[g])   sig[g] <= sig[g] + p_rd[g] * w_rd[g];
        end
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0d want %0d", name, idx, act, exp);
        end
    endtask

    function automatic int exp_res(input int j, input int relu);
        int s;
        s = bias[j];
        for (int i = 0; i < NI; i++) s += pix[i] * wt[j*NI + i];
        if (relu != 0 && s < 0) s = 0;
        return s;
    endfunction

    // Timeline model: k counts cycles since the accepted start (0 = idle).
    always @(negedge clk) begin
        int j, p;
        bit run, ab, lay;
        cyc++;
        if (!rstn) k = 0;
        run = (k != 0);
        ab  = run && abort;
        lay = (k >= 1) && (k <= TOT);
        j   = lay ? (k - 1) / PER : 0;
        p   = lay ? (k - 1) % PER : -1;
        for (int g = 0; g < 2; g++) begin
            chk("busy", g, busy[g], run);
            chk("n_clear", g, n_clear[g], (!run && start && !abort) || ab);
            chk("n_set_bias", g, n_set_bias[g], lay && p == 1 && !ab);
            chk("n_active", g, n_active[g], lay && p >= 2 && p <= NI + 1 && !ab);
            chk("res_we", g, res_we[g], lay && p == NI + 2 && !ab);
            chk("done", g, done[g], k == TOT + 1 && !ab);
            if (lay && !ab) begin
                if (p == 0) begin
                    chk("bias_addr", g, bias_addr[g], j);
                end else if (p == 1) begin
                    chk("pix_addr_load", g, pix_addr[g], 0);
                    chk("w_addr_load", g, w_addr[g], j * NI);
                end else if (p >= 2 && p < NI + 1) begin
                    chk("pix_addr_acc", g, pix_addr[g], p - 1);
                    chk("w_addr_acc", g, w_addr[g], j * NI + p - 1);
                end else if (p == NI + 2) begin
                    chk("res_addr", g, res_addr[g], j);
                    chk("res_data", g, res_data[g], exp_res(j, g));
                end
            end
            if (res_we[g]) wlog.push_back('{g, int'(res_addr[g]), int'(res_data[g])});
            if (done[g]) done_cnt[g]++;
            if (busy[g]) busy_cnt[g]++;
            if (n_active[g]) act_cnt[g]++;
        end
        if (done[0]) done_cyc = cyc;
        if (!rstn || ab) k = 0;
        else if (!run && start && !abort) begin k = 1; start_cyc = cyc; end
        else if (k == TOT + 1) k = 0;
        else if (run) k++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TOT + 2) tick();
    endtask

    // Four writes expected per full layer: (dut0,a0),(dut1,a0),(dut0,a1),(dut1,a1); result0 is 20.
    task automatic chk_run(input string tag, input int b, input int r1g0, input int r1g1);
        chk({tag, "_nwr"}, 0, wlog.size() - b, 4);
        if (wlog.size() - b == 4) begin
            for (int n = 0; n < 4; n++) begin
                chk({tag, "_wr_dut"}, n, wlog[b+n].g, n % 2);
                chk({tag, "_wr_addr"}, n, wlog[b+n].a, n / 2);
                chk({tag, "_wr_data"}, n, wlog[b+n].d, (n < 2) ? 20 : ((n == 2) ? r1g0 : r1g1));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_busy"}, g, busy[g], 0);
            chk({tag, "_done"}, g, done[g], 0);
            chk({tag, "_n_clear"}, g, n_clear[g], 0);
            chk({tag, "_n_set_bias"}, g, n_set_bias[g], 0);
            chk({tag, "_n_active"}, g, n_active[g], 0);
            chk({tag, "_res_we"}, g, res_we[g], 0);
            chk({tag, "_bias_addr"}, g, bias_addr[g], 0);
            chk({tag, "_pix_addr"}, g, pix_addr[g], 0);
            chk({tag, "_w_addr"}, g, w_addr[g], 0);
            chk({tag, "_res_addr"}, g, res_addr[g], 0);
            chk({tag, "_res_data"}, g, res_data[g], 0);
        end
    endtask

    initial begin
        pix  = '{1, 2, 3, 4};
        wt   = '{1, 1, 1, 1, 2, 0, 0, 1};
        bias = '{10, -5};
        tick();
        tick();
        chk_zero("reset");
        rstn = 1'b1;
        tick();

        // Basic layer: results 20 and 1, done 15 cycles after start.
        base = wlog.size(); d0 = done_cnt[0]; bc0 = busy_cnt[0]; ac0 = act_cnt[0];
        run_layer();
        chk_run("basic", base, 1, 1);
        chk("basic_done_cnt", 0, done_cnt[0] - d0, 1);
        chk("basic_busy_cycles", 0, busy_cnt[0] - bc0, 15);
        chk("basic_done_latency", 0, done_cyc - start_cyc, 15);
        chk("basic_active_cycles", 0, act_cnt[0] - ac0, 8);

        // Negative second sum: passed through on RELU=0, clamped on RELU=1.
        bias[1] = -20;
        base = wlog.size();
        run_layer();
        chk_run("relu", base, -14, 0);
        bias[1] = -5;

        // Abort in the third ACC cycle of neuron 1 (k = 12).
        base = wlog.size(); d0 = done_cnt[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        abort = 1'b1;
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("abort_n_clear", g, n_clear[g], 1);
            chk("abort_res_we", g, res_we[g], 0);
        end
        tick();
        abort = 1'b0;
        for (int g = 0; g < 2; g++) chk("abort_busy_next", g, busy[g], 0);
        repeat (20) tick();
        chk("abort_done_cnt", 0, done_cnt[0] - d0, 0);
        chk("abort_nwr", 0, wlog.size() - base, 2);
        if (wlog.size() - base == 2) begin
            for (int n = 0; n < 2; n++) begin
                chk("abort_wr_addr", n, wlog[base+n].a, 0);
                chk("abort_wr_data", n, wlog[base+n].d, 20);
            end
        end
        base = wlog.size();
        run_layer();
        chk_run("restart", base, 1, 1);

        // Second start while busy is ignored.
        base = wlog.size(); d0 = done_cnt[0]; bc0 = busy_cnt[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TOT) tick();
        chk_run("busy_start", base, 1, 1);
        chk("busy_start_done_cnt", 0, done_cnt[0] - d0, 1);
        chk("busy_start_busy_cycles", 0, busy_cnt[0] - bc0, 15);

        // Start together with abort while idle does not start.
        bc0 = busy_cnt[0]; bc1 = busy_cnt[1]; base = wlog.size();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) tick();
        chk("start_abort_busy", 0, busy_cnt[0] - bc0, 0);
        chk("start_abort_busy", 1, busy_cnt[1] - bc1, 0);
        chk("start_abort_nwr", 0, wlog.size() - base, 0);

        // Asynchronous reset in the middle of ACC of neuron 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        chk_zero("async_reset");
        tick();
        rstn = 1'b1;
        tick();
        base = wlog.size();
        run_layer();
        chk_run("after_reset", base, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
